// File: rtl/ad9280_acq_sequencer.sv
// Frame acquisition sequencer between an AD9280 capture core and a byte stream sink.
// Optional auto-trigger timeout is built when ACQ_AUTO_TIMEOUT_EN is defined.
module ad9280_acq_sequencer #(
  parameter int SAMPLE_DEPTH_WIDTH = 16,
  parameter int TIMEOUT_WIDTH      = 24
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          continuous,
  input  logic [SAMPLE_DEPTH_WIDTH-1:0] frame_len,
  input  logic [TIMEOUT_WIDTH-1:0]      timeout_cycles,
  output logic                          core_sampling_enable,
  output logic [SAMPLE_DEPTH_WIDTH-1:0] core_sample_depth,
  output logic                          core_software_trigger,
  input  logic                          core_trigger_detected,
  input  logic                          core_acq_complete,
  input  logic                          core_data_valid,
  input  logic [7:0]                    core_data,
  output logic                          core_data_ready,
  output logic [7:0]                    m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic                          busy,
  output logic                          frame_done,
  output logic [15:0]                   frame_count,
  output logic                          underrun,
  output logic                          timed_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_TRIG, S_CAPTURE, S_DRAIN, S_GAP
  } state_t;

  state_t                        state_q, state_d;
  logic [SAMPLE_DEPTH_WIDTH-1:0] depth_q, depth_d;
  logic [SAMPLE_DEPTH_WIDTH-1:0] beat_q, beat_d;
  logic [1:0]                    idle_q, idle_d;
  logic                          gap_q, gap_d;
  logic                          frame_done_q, frame_done_d;
  logic [15:0]                   frame_count_q, frame_count_d;
  logic                          underrun_q, underrun_d;

  logic pass, beat_acc, last_beat, abort;

  assign pass      = (state_q == S_CAPTURE) || (state_q == S_DRAIN);
  assign beat_acc  = m_tvalid && m_tready;
  assign last_beat = (beat_q == depth_q - SAMPLE_DEPTH_WIDTH'(1));
  assign abort     = stop && (state_q != S_IDLE);

  // Stream is a zero-latency pass-through of the core while a frame is open.
  assign m_tvalid        = pass && core_data_valid;
  assign m_tdata         = pass ? core_data : 8'h00;
  assign m_tlast         = m_tvalid && last_beat;
  assign core_data_ready = pass ? m_tready : (state_q == S_WAIT_TRIG);

  assign core_sampling_enable = (state_q == S_ARM) || (state_q == S_WAIT_TRIG) || pass;
  assign core_sample_depth    = depth_q;
  assign busy                 = (state_q != S_IDLE);
  assign frame_done           = frame_done_q;
  assign frame_count          = frame_count_q;
  assign underrun             = underrun_q;

  always_comb begin
    state_d       = state_q;
    depth_d       = depth_q;
    beat_d        = beat_q;
    idle_d        = idle_q;
    gap_d         = gap_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    underrun_d    = underrun_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ARM;
          depth_d    = (frame_len == '0) ? SAMPLE_DEPTH_WIDTH'(1) : frame_len;
          beat_d     = '0;
          underrun_d = 1'b0;
        end
      end
      S_ARM: begin
        state_d = S_WAIT_TRIG;
        beat_d  = '0;
        idle_d  = 2'd0;
      end
      S_WAIT_TRIG: begin
        if (core_trigger_detected) state_d = S_CAPTURE;
      end
      S_CAPTURE, S_DRAIN: begin
        if (beat_acc) begin
          beat_d = beat_q + SAMPLE_DEPTH_WIDTH'(1);
          if (last_beat) begin
            state_d       = S_GAP;
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
          end
        end
        if (state_q == S_CAPTURE) begin
          if (core_acq_complete && !(beat_acc && last_beat)) state_d = S_DRAIN;
        end else if (core_data_valid) begin
          idle_d = 2'd0;
        end else if (idle_q == 2'd3) begin
          // core stalled for four cycles short of a full frame: close it out
          state_d       = S_GAP;
          underrun_d    = 1'b1;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          idle_d        = 2'd0;
        end else begin
          idle_d = idle_q + 2'd1;
        end
      end
      S_GAP: begin
        gap_d = ~gap_q;
        if (gap_q) state_d = continuous ? S_ARM : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d       = S_IDLE;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;
      gap_d         = 1'b0;
      idle_d        = 2'd0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= S_IDLE;
      depth_q       <= '0;
      beat_q        <= '0;
      idle_q        <= 2'd0;
      gap_q         <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'd0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      depth_q       <= depth_d;
      beat_q        <= beat_d;
      idle_q        <= idle_d;
      gap_q         <= gap_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      underrun_q    <= underrun_d;
    end
  end

`ifdef ACQ_AUTO_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] to_cnt_q, to_cnt_d;
  logic                     sw_trig_q, sw_trig_d;
  logic                     timed_out_q, timed_out_d;

  // Counter saturates at the limit so the software trigger fires only once per wait.
  always_comb begin
    to_cnt_d    = to_cnt_q;
    sw_trig_d   = 1'b0;
    timed_out_d = timed_out_q;
    if (state_q == S_IDLE && start) timed_out_d = 1'b0;
    if (state_q == S_ARM) to_cnt_d = '0;
    if (state_q == S_WAIT_TRIG && to_cnt_q != timeout_cycles) begin
      to_cnt_d = to_cnt_q + TIMEOUT_WIDTH'(1);
      if (to_cnt_d == timeout_cycles) begin
        sw_trig_d   = 1'b1;
        timed_out_d = 1'b1;
      end
    end
    if (abort) sw_trig_d = 1'b0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      to_cnt_q    <= '0;
      sw_trig_q   <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      to_cnt_q    <= to_cnt_d;
      sw_trig_q   <= sw_trig_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign core_software_trigger = sw_trig_q;
  assign timed_out             = timed_out_q;
`else
  logic unused_timeout;
  assign unused_timeout        = ^timeout_cycles;
  assign core_software_trigger = 1'b0;
  assign timed_out             = 1'b0;
`endif

endmodule

// File: tb/tb_ad9280_acq_sequencer.sv
// Scoreboard bench for ad9280_acq_sequencer: directed frames, monitor checks every accepted beat.
module tb_ad9280_acq_sequencer;

  logic        sys_clk, sys_rst_n;
  logic        start, stop, continuous;
  logic [15:0] frame_len;
  logic [23:0] timeout_cycles;
  logic        core_sampling_enable, core_software_trigger;
  logic [15:0] core_sample_depth;
  logic        core_trigger_detected, core_acq_complete, core_data_valid;
  logic [7:0]  core_data;
  logic        core_data_ready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic        busy, frame_done, underrun, timed_out;
  logic [15:0] frame_count;

  ad9280_acq_sequencer dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .stop(stop),
    .continuous(continuous), .frame_len(frame_len), .timeout_cycles(timeout_cycles),
    .core_sampling_enable(core_sampling_enable), .core_sample_depth(core_sample_depth),
    .core_software_trigger(core_software_trigger), .core_trigger_detected(core_trigger_detected),
    .core_acq_complete(core_acq_complete), .core_data_valid(core_data_valid),
    .core_data(core_data), .core_data_ready(core_data_ready), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count), .underrun(underrun),
    .timed_out(timed_out)
  );

  typedef struct packed {logic last; logic [7:0] data;} beat_t;

  beat_t exp_q[$];
  int    checks = 0, errors = 0;
  int    fd_cnt = 0, acc_cnt = 0, sw_cnt = 0, run = 0;
  int    gaps[$];
  int    exp_fc = 0;
  logic  prev_fd = 1'b0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat, tracks status pulses.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (m_tvalid && m_tready) begin
        acc_cnt++;
        if (exp_q.size() == 0) chk("unexpected_beat", {23'd0, m_tlast, m_tdata}, 32'hFFFF_FFFF);
        else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", {24'd0, m_tdata}, {24'd0, e.data});
          chk("beat_last", {31'd0, m_tlast}, {31'd0, e.last});
        end
      end
      if (frame_done) begin
        fd_cnt++;
        chk("frame_done_width", {31'd0, prev_fd}, 32'd0);
      end
      prev_fd = frame_done;
      if (core_software_trigger) sw_cnt++;
      if (!busy) run = 0;
      else if (!core_sampling_enable) run++;
      else if (run > 0) begin
        gaps.push_back(run);
        run = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic start_frame(input logic [15:0] len);
    frame_len = len; start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic trig(input int pre);
    cyc(pre); core_trigger_detected = 1'b1; cyc(1); core_trigger_detected = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input bit tog);
    int budget;
    bit acc;
    budget = 50;
    acc = 1'b0;
    core_data = d; core_data_valid = 1'b1;
    exp_q.push_back('{last: last, data: d});
    do begin
      @(negedge sys_clk); acc = m_tvalid && m_tready;
      @(posedge sys_clk); #1;
      if (tog) m_tready = ~m_tready;
      budget--;
    end while (!acc && budget > 0);
    if (!acc) chk("beat_accept_timeout", 32'd0, 32'd1);
    core_data_valid = 1'b0;
  endtask

  initial begin
    int fd0, n;
    start = 0; stop = 0; continuous = 0; frame_len = 0; timeout_cycles = 24'd100;
    core_trigger_detected = 0; core_acq_complete = 0; core_data_valid = 0;
    core_data = 0; m_tready = 1; sys_rst_n = 1;
    #2 sys_rst_n = 0;
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_tvalid", {31'd0, m_tvalid}, 0);
    chk("rst_enable", {31'd0, core_sampling_enable}, 0);
    chk("rst_depth", {16'd0, core_sample_depth}, 0);
    chk("rst_fcount", {16'd0, frame_count}, 0);
    chk("rst_flags", {28'd0, underrun, timed_out, frame_done, core_software_trigger}, 0);
    chk("rst_ready_last", {30'd0, core_data_ready, m_tlast}, 0);
    cyc(3);
    sys_rst_n = 1;
    cyc(2);

    // 8-beat frame, trigger around cycle 10, WAIT_TRIG flushes core data
    start_frame(16'd8);
    cyc(3);
    core_data_valid = 1; core_data = 8'hEE;
    @(negedge sys_clk);
    chk("wait_tvalid", {31'd0, m_tvalid}, 0);
    chk("wait_ready", {31'd0, core_data_ready}, 1);
    chk("wait_enable_busy", {30'd0, core_sampling_enable, busy}, 3);
    chk("depth8", {16'd0, core_sample_depth}, 8);
    @(posedge sys_clk); #1 core_data_valid = 0;
    trig(4);
    for (int i = 0; i < 8; i++) send_beat(8'h10 + 8'(i), i == 7, 0);
    exp_fc++;
    cyc(5);
    chk("t1_fd", fd_cnt, 1);
    chk("t1_fcount", {16'd0, frame_count}, exp_fc);
    chk("t1_idle", {31'd0, busy}, 0);

    // 4-beat frame with back-pressure toggling every cycle
    fd0 = fd_cnt; acc_cnt = 0;
    start_frame(16'd4);
    trig(3);
    for (int i = 0; i < 4; i++) send_beat(8'hA0 + 8'(i), i == 3, 1);
    m_tready = 1;
    exp_fc++;
    cyc(5);
    chk("t2_beats", acc_cnt, 4);
    chk("t2_fd", fd_cnt - fd0, 1);
    chk("t2_fcount", {16'd0, frame_count}, exp_fc);

    // continuous mode: three frames separated by a 2-cycle enable gap
    fd0 = fd_cnt; gaps.delete(); continuous = 1;
    start_frame(16'd4);
    for (int f = 0; f < 3; f++) begin
      trig(f == 0 ? 3 : 4);
      if (f == 2) continuous = 0;
      for (int i = 0; i < 4; i++) send_beat(8'(8'h40 * f + i), i == 3, 0);
      exp_fc++;
    end
    cyc(6);
    chk("t3_fd", fd_cnt - fd0, 3);
    chk("t3_fcount", {16'd0, frame_count}, exp_fc);
    chk("t3_gap_n", gaps.size(), 2);
    foreach (gaps[k]) chk("t3_gap_len", gaps[k], 2);
    chk("t3_idle", {31'd0, busy}, 0);

    // stop at beat 2 of an 8-beat frame
    fd0 = fd_cnt;
    start_frame(16'd8);
    trig(3);
    send_beat(8'h71, 0, 0);
    send_beat(8'h72, 0, 0);
    stop = 1; start = 1; cyc(1); stop = 0; start = 0;
    core_data_valid = 1; core_data = 8'h73;
    #1;
    chk("t4_busy", {31'd0, busy}, 0);
    chk("t4_tvalid", {31'd0, m_tvalid}, 0);
    @(posedge sys_clk); #1 core_data_valid = 0;
    cyc(3);
    chk("t4_fd", fd_cnt - fd0, 0);
    chk("t4_fcount", {16'd0, frame_count}, exp_fc);

    // underrun: acq_complete after 5 beats, core goes quiet
    fd0 = fd_cnt;
    start_frame(16'd8);
    trig(3);
    for (int i = 0; i < 5; i++) send_beat(8'h80 + 8'(i), 0, 0);
    core_acq_complete = 1; cyc(1); core_acq_complete = 0;
    cyc(3);
    chk("t5_not_yet", {31'd0, underrun}, 0);
    cyc(8);
    chk("t5_underrun", {31'd0, underrun}, 1);
    chk("t5_fd", fd_cnt - fd0, 1);
    chk("t5_idle", {31'd0, busy}, 0);

    // frame_len=0 acts as 1; start clears sticky underrun
    fd0 = fd_cnt;
    start_frame(16'd0);
    chk("t6_depth", {16'd0, core_sample_depth}, 1);
    chk("t6_underrun_clr", {31'd0, underrun}, 0);
    trig(3);
    send_beat(8'h5A, 1, 0);
    cyc(4);
    chk("t6_fd", fd_cnt - fd0, 1);

    // auto-trigger timeout
    sw_cnt = 0;
    start_frame(16'd4);
`ifdef ACQ_AUTO_TIMEOUT_EN
    n = 0;
    while (!core_software_trigger && n < 300) begin cyc(1); n++; end
    chk("t7_sw_delay", n, 101);
    chk("t7_timed_out", {31'd0, timed_out}, 1);
    cyc(3);
    chk("t7_sw_pulses", sw_cnt, 1);
`else
    n = 0;
    cyc(130);
    chk("t7_no_sw", sw_cnt + n, 0);
    chk("t7_no_timeout", {31'd0, timed_out}, 0);
    chk("t7_still_waiting", {31'd0, busy}, 1);
`endif
    stop = 1; cyc(1); stop = 0;
    chk("t7_stopped", {31'd0, busy}, 0);

    // reset mid-frame drops the stream at once
    start_frame(16'd8);
    trig(3);
    send_beat(8'h91, 0, 0);
    core_data_valid = 1; core_data = 8'h92;
    #1 sys_rst_n = 0;
    #1;
    chk("t8_tvalid", {31'd0, m_tvalid}, 0);
    chk("t8_busy", {31'd0, busy}, 0);
    chk("t8_fcount", {16'd0, frame_count}, 0);
    core_data_valid = 0;
    cyc(2);
    sys_rst_n = 1;
    cyc(2);
    chk("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
